sum_display_driver: RTL and testbench
=====================================

// Module: sum_display_driver
// PURPOSE
//   Downstream stage of the 4-bit ripple adder. It captures the adder's 5-bit
//   sum (0..31) on a load strobe and converts it to two BCD digits with a
//   sequential shift-add-3 (double-dabble) engine. It then drives a
//   time-multiplexed two-digit common-bus 7-segment display on uo_out.
// PARAMETERS
//   REFRESH_DIV  1024  clock cycles each digit is shown before digit_sel toggles (>=2)
//   BLANK_LZ     1     1: tens digit blanked (seg=0) when tens==0; 0: shows "0"
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   rst        in   1  synchronous reset, active-high
//   sum_in     in   5  adder result {Cout,S[3:0]}, sampled only on accepted load
//   load       in   1  request to capture sum_in; accepted when load && ready
//   ready      out  1  1 = idle, can accept load; 0 = conversion in progress
//   bcd_out    out  8  registered displayed value {tens[3:0],units[3:0]}
//   seg        out  7  registered segment drive, active-high, seg[6:0]={g,f,e,d,c,b,a}
//   digit_sel  out  1  registered digit enable: 0 = units digit, 1 = tens digit
// BEHAVIOUR
// - Reset (rst high at an edge): state=IDLE, ready=1, bcd_out=8'h00, seg=7'b0,
//   digit_sel=0, refresh counter=0, shift register and iteration count=0.
// - FSM states: IDLE, CONVERT.
//   - IDLE -> CONVERT on an edge with load=1. sum_in is latched into the shift
//     register, the BCD scratch is cleared, iter=0, and ready goes 0.
//   - CONVERT: each edge, if units scratch >=5 add 3, then shift
//     {tens,units,bin} left by 1, iter++. Tens is never >=5 for 5-bit input.
//   - On the 5th CONVERT edge, the scratch result is written to bcd_out, the
//     state returns to IDLE and ready=1.
//   - ready is low for exactly 5 cycles per accepted load. bcd_out changes only
//     on that 5th edge, never mid-conversion.
// - load while ready=0 is ignored: no queueing and no restart. load in the
//   same cycle ready rises is not accepted; ready is a registered output.
// - Width rules: the scratch is {tens[3:0],units[3:0],bin[4:0]} = 13 bits.
//   Input 31 yields 8'h31; no overflow path exists.
// - Refresh: the counter runs freely 0..REFRESH_DIV-1, independent of the FSM.
//   On the wrap edge, digit_sel toggles.
// - seg is the decode of the digit selected by the next-cycle digit_sel and the
//   current bcd_out, registered together with digit_sel. seg and digit_sel
//   therefore always change on the same edge and are never mismatched.
// - Decode (gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//   5=1101101 6=1111101 7=0000111 8=1111111 9=1101111, others=0000000.
// - Blanking: when digit_sel=1, tens==0 and BLANK_LZ=1, seg=0000000.
// - First edge after reset release: seg=0111111 (units "0"), digit_sel=0.
// - rst during CONVERT aborts the conversion. bcd_out returns to 8'h00, the
//   partial result is discarded, and ready=1 on the next cycle.
// - The display keeps multiplexing during CONVERT, showing the previous
//   bcd_out.
// TESTING (bench uses REFRESH_DIV=4, BLANK_LZ=1)
//   1. Hold rst 2 cycles, release -> ready=1, bcd_out=00, digit_sel=0,
//      seg=0111111; digit_sel=1 with seg=0000000 after 4 cycles.
//   2. load with sum_in=30 -> ready=0 for 5 cycles, then bcd_out=8'h30;
//      units seg=0111111, tens seg=1001111.
//   3. load with sum_in=7 -> bcd_out=8'h07; units seg=0000111; tens seg=0000000
//      (blanked). Repeat with BLANK_LZ=0 -> tens seg=0111111.
//   4. load 31, then load 5 two cycles later (busy) -> second load ignored;
//      bcd_out=8'h31, ready high once; seg 0000110 / 1001111.
//   5. load 19, assert rst on 3rd CONVERT cycle -> bcd_out=00, ready=1 next
//      cycle; a following load 12 -> bcd_out=8'h12.
//   6. Sweep sum_in 0..31 back-to-back (load whenever ready) -> bcd_out equals
//      the decimal of each input; seg matches the decode table on both digits.

Source files
------------

// File: rtl/sum_display_driver.sv
// sum_display_driver: latches a 5-bit sum on load (ready=idle), converts it to BCD by shift-add-3 into bcd_out, and multiplexes the two digits onto seg/digit_sel
module sum_display_driver #(
  parameter int REFRESH_DIV = 1024,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       load,
  output logic       ready,
  output logic [7:0] bcd_out,
  output logic [6:0] seg,
  output logic       digit_sel
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic {IDLE, CONVERT} state_t;
  state_t      r_state, w_state_nxt;
  logic [12:0] r_sr, w_sr_nxt;
  logic [3:0]  w_units;
  logic [2:0]  r_iter;
  logic [CW-1:0] r_cnt;
  logic        w_wrap, w_sel_nxt, w_blank;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg_nxt;
  assign ready = r_state == IDLE;
  always_comb begin
    w_units     = r_sr[8:5] >= 4'd5 ? r_sr[8:5] + 4'd3 : r_sr[8:5];
    w_sr_nxt    = {r_sr[12:9], w_units, r_sr[4:0]} << 1;
    w_state_nxt = r_state == IDLE ? (load ? CONVERT : IDLE) : (r_iter == 3'd4 ? IDLE : CONVERT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_iter  <= '0;
      bcd_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && load) begin
        r_sr   <= {8'd0, sum_in};
        r_iter <= '0;
      end else if (r_state == CONVERT) begin
        r_sr   <= w_sr_nxt;
        r_iter <= r_iter + 3'd1;
        if (r_iter == 3'd4) bcd_out <= w_sr_nxt[12:5];
      end
    end
  end
  // seg is decoded from the digit that will be selected after this edge so both update together
  always_comb begin
    w_wrap    = r_cnt == CW'(REFRESH_DIV - 1);
    w_sel_nxt = digit_sel ^ w_wrap;
    w_digit   = w_sel_nxt ? bcd_out[7:4] : bcd_out[3:0];
    w_blank   = BLANK_LZ && w_sel_nxt && bcd_out[7:4] == 4'd0;
    case (w_digit)
      4'd0:    w_seg_nxt = 7'b0111111;
      4'd1:    w_seg_nxt = 7'b0000110;
      4'd2:    w_seg_nxt = 7'b1011011;
      4'd3:    w_seg_nxt = 7'b1001111;
      4'd4:    w_seg_nxt = 7'b1100110;
      4'd5:    w_seg_nxt = 7'b1101101;
      4'd6:    w_seg_nxt = 7'b1111101;
      4'd7:    w_seg_nxt = 7'b0000111;
      4'd8:    w_seg_nxt = 7'b1111111;
      4'd9:    w_seg_nxt = 7'b1101111;
      default: w_seg_nxt = 7'b0000000;
    endcase
    if (w_blank) w_seg_nxt = 7'b0000000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      digit_sel <= 1'b0;
      seg       <= '0;
    end else begin
      r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
      digit_sel <= w_sel_nxt;
      seg       <= w_seg_nxt;
    end
  end
endmodule

// File: tb/tb_sum_display_driver.sv
// tb_sum_display_driver: directed and random stimulus checked each cycle against a decimal-arithmetic reference model
module tb_sum_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1, load = 1'b0;
  logic [4:0] sum_in = '0;
  logic ready, digit_sel, ready0, digit_sel0;
  logic [7:0] bcd_out, bcd_out0;
  logic [6:0] seg, seg0;
  int n_chk = 0, n_fail = 0;
  int m_k, m_rem, m_val;
  logic [7:0] m_bcd;
  logic m_sel;
  logic [6:0] m_seg, m_seg0;
  localparam logic [6:0] SEG_T [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  sum_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .load(load), .ready(ready),
    .bcd_out(bcd_out), .seg(seg), .digit_sel(digit_sel));
  sum_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .load(load), .ready(ready0),
    .bcd_out(bcd_out0), .seg(seg0), .digit_sel(digit_sel0));
  always #5 clk = ~clk;
  function automatic logic [6:0] segof(input int d);
    return (d >= 0 && d < 10) ? SEG_T[d] : 7'h00;
  endfunction
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    int tens, units;
    if (rst) begin
      m_k = 0; m_rem = 0; m_bcd = '0; m_sel = 1'b0; m_seg = '0; m_seg0 = '0;
    end else begin
      m_k++;
      m_sel = 1'((m_k / 4) % 2);
      tens  = int'(m_bcd) / 16;
      units = int'(m_bcd) % 16;
      m_seg  = m_sel ? (tens == 0 ? 7'h00 : segof(tens)) : segof(units);
      m_seg0 = m_sel ? segof(tens) : segof(units);
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_bcd = to_bcd(m_val);
      end else if (load) begin
        m_rem = 5;
        m_val = int'(sum_in);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", {7'd0, ready}, {7'd0, m_rem == 0});
    chk("bcd_out", bcd_out, m_bcd);
    chk("digit_sel", {7'd0, digit_sel}, {7'd0, m_sel});
    chk("seg", {1'b0, seg}, {1'b0, m_seg});
    chk("ready_lz0", {7'd0, ready0}, {7'd0, m_rem == 0});
    chk("bcd_lz0", bcd_out0, m_bcd);
    chk("sel_lz0", {7'd0, digit_sel0}, {7'd0, m_sel});
    chk("seg_lz0", {1'b0, seg0}, {1'b0, m_seg0});
  endtask
  task automatic drive(input logic r, input logic l, input logic [4:0] v);
    rst = r; load = l; sum_in = v;
    tick();
  endtask
  task automatic load_wait(input logic [4:0] v, output int n);
    drive(1'b0, 1'b1, v);
    n = 0;
    while (!ready && n < 12) begin
      drive(1'b0, 1'b0, 5'd0);
      n++;
    end
    chk("wait_ready", {7'd0, ready}, 8'd1);
  endtask
  task automatic show_digits(input logic [6:0] u, input logic [6:0] t, input logic [6:0] t0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 5'd0);
      if (digit_sel) begin
        chk("tens_seg", {1'b0, seg}, {1'b0, t});
        chk("tens_seg_lz0", {1'b0, seg0}, {1'b0, t0});
      end else chk("units_seg", {1'b0, seg}, {1'b0, u});
    end
  endtask
  initial begin
    int n;
    drive(1'b1, 1'b0, 5'd0);
    drive(1'b1, 1'b0, 5'd0);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    drive(1'b0, 1'b0, 5'd0);
    chk("first_seg", {1'b0, seg}, 8'h3F);
    chk("first_sel", {7'd0, digit_sel}, 8'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0);
    chk("sel_after4", {7'd0, digit_sel}, 8'd1);
    chk("blank_after4", {1'b0, seg}, 8'h00);
    load_wait(5'd30, n);
    chk("busy_len", 8'(n), 8'd5);
    chk("bcd_30", bcd_out, 8'h30);
    show_digits(7'b0111111, 7'b1001111, 7'b1001111);
    load_wait(5'd7, n);
    chk("bcd_07", bcd_out, 8'h07);
    show_digits(7'b0000111, 7'b0000000, 7'b0111111);
    drive(1'b0, 1'b1, 5'd31);
    drive(1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 5'd5);
    n = 0;
    while (!ready && n < 12) begin
      drive(1'b0, 1'b0, 5'd0);
      n++;
    end
    chk("bcd_31", bcd_out, 8'h31);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 5'd0);
    chk("no_queue", bcd_out, 8'h31);
    chk("ready_held", {7'd0, ready}, 8'd1);
    show_digits(7'b0000110, 7'b1001111, 7'b1001111);
    drive(1'b0, 1'b1, 5'd19);
    drive(1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0);
    drive(1'b1, 1'b0, 5'd0);
    chk("abort_bcd", bcd_out, 8'h00);
    chk("abort_ready", {7'd0, ready}, 8'd1);
    drive(1'b0, 1'b0, 5'd0);
    load_wait(5'd12, n);
    chk("bcd_12", bcd_out, 8'h12);
    for (int v = 0; v < 32; v++) begin
      load_wait(5'(v), n);
      chk("sweep_bcd", bcd_out, to_bcd(v));
    end
    for (int i = 0; i < 400; i++)
      drive($urandom_range(63) == 0, $urandom_range(2) == 0, 5'($urandom_range(31)));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
